issue_scheduler: RTL and testbench

- Per-cycle issue arbiter between the four issue queues: int, mult, div, ld_st.
- Grants at most one queue per cycle, using round-robin priority.
- Reserves the common data bus (CDB) slot in which each issued op's result will be broadcast, so no two results collide.
- Sits between the issue-queue head-ready signals and the execution units; also drives the CDB source select.

---
 rtl/issue_scheduler.sv | 96 +++++++++
 tb/tb_issue_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: round-robin issue arbiter with CDB slot reservation; optional perf counters via ISSUE_SCHED_PERF_EN
module issue_scheduler #(
  parameter int INT_LAT  = 1,
  parameter int LDST_LAT = 2,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_ready,
  input  logic        ld_st_ready,
  input  logic        mult_ready,
  input  logic        div_ready,
  input  logic        flush,
  output logic        issue_int,
  output logic        issue_ld_st,
  output logic        issue_mult,
  output logic        issue_div,
  output logic        div_busy,
  output logic [3:0]  cdb_owner
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] issue_cnt
`endif
);
  localparam int N  = DIV_LAT;
  localparam int CW = $clog2(DIV_LAT + 1);
  logic [N:1]        vld;
  logic [N:1][1:0]   uid;
  logic [N+1:1]      vx;
  logic [1:0]        rr_ptr;
  logic [1:0]        gid;
  logic [CW-1:0]     cnt;
  logic [3:0]        elig;
  logic [3:0]        gnt;
  // slot N+1 never exists, so the longest-latency unit always sees a free slot
  assign vx   = {1'b0, vld};
  assign elig = {div_ready && !vx[DIV_LAT+1] && cnt == '0,
                 mult_ready && !vx[MULT_LAT+1],
                 ld_st_ready && !vx[LDST_LAT+1],
                 int_ready && !vx[INT_LAT+1]} & {4{!flush}};
  // scan from rr_ptr downward in reverse so the nearest eligible index wins
  always_comb begin
    gid = rr_ptr;
    for (int i = 3; i >= 0; i--)
      if (elig[rr_ptr + 2'(i)]) gid = rr_ptr + 2'(i);
  end
  assign gnt = elig[gid] ? 4'b1 << gid : 4'b0;
  assign {issue_div, issue_mult, issue_ld_st, issue_int} = gnt;
  assign div_busy  = cnt != '0;
  assign cdb_owner = vld[1] ? 4'b1 << uid[1] : 4'b0;
  // shift reservations toward the CDB slot; a new grant books its own slot
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      uid    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      vld <= {1'b0, vld[N:2]};
      uid <= {2'b00, uid[N:2]};
      if (gnt[0]) begin
        vld[INT_LAT] <= 1'b1;
        uid[INT_LAT] <= 2'd0;
      end
      if (gnt[1]) begin
        vld[LDST_LAT] <= 1'b1;
        uid[LDST_LAT] <= 2'd1;
      end
      if (gnt[2]) begin
        vld[MULT_LAT] <= 1'b1;
        uid[MULT_LAT] <= 2'd2;
      end
      if (gnt[3]) begin
        vld[DIV_LAT] <= 1'b1;
        uid[DIV_LAT] <= 2'd3;
      end
      if (|gnt) rr_ptr <= gid + 2'd1;
      cnt <= gnt[3] ? CW'(DIV_LAT - 1) : cnt - CW'(cnt != '0);
    end
  end
`ifdef ISSUE_SCHED_PERF_EN
  // stall counter saturates, issue counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if ((int_ready || ld_st_ready || mult_ready || div_ready) && !flush && gnt == '0 && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (|gnt) issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed plan plus random traffic against a cycle-booking reference model
module tb_issue_scheduler;
  logic clk = 0;
  logic rst, int_ready, ld_st_ready, mult_ready, div_ready, flush;
  logic issue_int, issue_ld_st, issue_mult, issue_div, div_busy;
  logic [3:0] cdb_owner;
`ifdef ISSUE_SCHED_PERF_EN
  logic [31:0] stall_cnt, issue_cnt;
`endif
  int checks = 0, failures = 0;
  int t = 0, rr = 0, div_free_at = 0;
  int book [0:63];
  longint stall_m = 0, issue_m = 0;
  int lat [4] = '{1, 2, 4, 6};
  logic [3:0] g_obs, c_obs;

  issue_scheduler dut (
    .clk(clk), .rst(rst), .int_ready(int_ready), .ld_st_ready(ld_st_ready),
    .mult_ready(mult_ready), .div_ready(div_ready), .flush(flush),
    .issue_int(issue_int), .issue_ld_st(issue_ld_st), .issue_mult(issue_mult),
    .issue_div(issue_div), .div_busy(div_busy), .cdb_owner(cdb_owner)
`ifdef ISSUE_SCHED_PERF_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, o, e, t);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) book[i] = -1;
    rr = 0;
    div_free_at = 0;
    stall_m = 0;
    issue_m = 0;
  endtask

  // one clock cycle: drive at negedge, check before posedge, then advance the model past the edge
  task automatic cyc(input logic [3:0] rdy, input logic fl, input logic rs);
    int win;
    logic [3:0] eg, ec;
    @(negedge clk);
    {div_ready, mult_ready, ld_st_ready, int_ready} = rdy;
    flush = fl;
    rst = rs;
    #1;
    win = -1;
    for (int i = 0; i < 4; i++) begin
      int u;
      u = (rr + i) % 4;
      if (win < 0 && rdy[u] && !fl && book[(t + lat[u]) % 64] < 0 && (u != 3 || t >= div_free_at)) win = u;
    end
    eg = (win >= 0) ? 4'(1 << win) : 4'b0;
    ec = (book[t % 64] >= 0) ? 4'(1 << book[t % 64]) : 4'b0;
    g_obs = {issue_div, issue_mult, issue_ld_st, issue_int};
    c_obs = cdb_owner;
    chk("grant", 32'(g_obs), 32'(eg));
    chk("cdb_owner", 32'(c_obs), 32'(ec));
    chk("div_busy", 32'(div_busy), 32'(t < div_free_at));
    chk("cdb_onehot", 32'($countones(cdb_owner) <= 1), 32'd1);
`ifdef ISSUE_SCHED_PERF_EN
    chk("stall_cnt", stall_cnt, 32'(stall_m));
    chk("issue_cnt", issue_cnt, 32'(issue_m));
`endif
    book[t % 64] = -1;
    if (rs) model_clear();
    else begin
      if (rdy != 0 && !fl && win < 0 && stall_m != 64'hFFFF_FFFF) stall_m++;
      if (win >= 0) begin
        book[(t + lat[win]) % 64] = win;
        rr = (win + 1) % 4;
        if (win == 3) div_free_at = t + 6;
        issue_m = (issue_m + 1) % 64'h1_0000_0000;
      end
    end
    t++;
  endtask

  initial begin
    rst = 1;
    {int_ready, ld_st_ready, mult_ready, div_ready, flush} = '0;
    repeat (2) @(posedge clk);
    model_clear();
    // reset state
    cyc(4'b0000, 0, 1);
    chk("reset_cdb", 32'(cdb_owner), 32'd0);
    chk("reset_busy", 32'(div_busy), 32'd0);
    // plan 1: int back to back
    for (int i = 0; i < 4; i++) begin
      cyc(i < 3 ? 4'b0001 : 4'b0000, 0, 0);
      chk("t1_grant", 32'(g_obs), i < 3 ? 32'h1 : 32'h0);
      chk("t1_cdb", 32'(c_obs), i > 0 ? 32'h1 : 32'h0);
    end
    // plan 2: mult reservation blocks ld_st
    cyc(4'b0000, 0, 1);
    cyc(4'b0100, 0, 0);
    chk("t2_mult", 32'(g_obs), 32'h4);
    cyc(4'b0000, 0, 0);
    cyc(4'b0011, 0, 0);
    chk("t2_int_wins", 32'(g_obs), 32'h1);
    cyc(4'b0000, 0, 0);
    chk("t2_cdb3", 32'(c_obs), 32'h1);
    cyc(4'b0000, 0, 0);
    chk("t2_cdb4", 32'(c_obs), 32'h4);
    // plan 3: divider occupancy
    cyc(4'b0000, 0, 1);
    for (int i = 0; i <= 12; i++) begin
      cyc(4'b1000, 0, 0);
      chk("t3_div", 32'(g_obs[3]), 32'(i % 6 == 0));
      chk("t3_busy", 32'(div_busy), 32'(i % 6 != 0));
      if (i == 6 || i == 12) chk("t3_cdb", 32'(c_obs), 32'h8);
    end
    // plan 4: all four ready
    cyc(4'b0000, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cyc(4'b1111, 0, 0);
      if (i < 4) chk("t4_order", 32'(g_obs), 32'(1 << i));
    end
    // plan 5: flush blocks grants but reservations drain
    cyc(4'b0000, 0, 1);
    cyc(4'b0100, 0, 0);
    cyc(4'b0001, 1, 0);
    chk("t5_flush", 32'(g_obs), 32'h0);
    cyc(4'b0000, 0, 0);
    cyc(4'b0000, 0, 0);
    cyc(4'b0000, 0, 0);
    chk("t5_cdb4", 32'(c_obs), 32'h4);
    // plan 6: reset discards reservations
    cyc(4'b0000, 0, 1);
    cyc(4'b0100, 0, 0);
    cyc(4'b0000, 0, 0);
    cyc(4'b0000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 0, 0);
      chk("t6_cdb", 32'(c_obs), 32'h0);
    end
    cyc(4'b0011, 0, 0);
    chk("t6_rr0", 32'(g_obs), 32'h1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic rs;
      rs = ($urandom % 64) == 0;
      cyc(rs ? 4'b0000 : 4'($urandom), ($urandom % 8) == 0, rs);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
